// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the pipeline sequencing controller.
package cpu_defs;

    // PC source select encodings.
    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_EXC = 2'd1;
    localparam logic [1:0] PC_SEL_EPC = 2'd2;

    // Tuse value meaning "operand not read".
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Exception vector the PC mux selects with PC_SEL_EXC.
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    // Redirect FSM state encodings.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // True when a producer still in flight writes src later than the consumer needs it.
    // Tuse == TUSE_NONE can never be below a 2-bit Tnew, so unused operands never stall.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       wr,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        return wr && (dst == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy counter: loads the operation latency, counts down to zero.
module md_busy_cnt #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic is_div_i,
    output logic busy_o
);

    logic [3:0] cnt_q, cnt_d;

    // Next count: a new operation reloads, otherwise run down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = is_div_i ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: data/MDU stalls, exception and ERET redirects.
module pipe_hazard_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYC   = 5,
    parameter int unsigned DIV_CYC    = 10,
    parameter int unsigned REDIR_HOLD = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] D_Rs,
    input  logic [4:0] D_Rt,
    input  logic [1:0] D_TuseRs,
    input  logic [1:0] D_TuseRt,
    input  logic       D_isMD,
    input  logic       E_RegWrite,
    input  logic [4:0] E_RegDst,
    input  logic [1:0] E_Tnew,
    input  logic       M_RegWrite,
    input  logic [4:0] M_RegDst,
    input  logic [1:0] M_Tnew,
    input  logic       E_MDStart,
    input  logic       E_MDIsDiv,
    input  logic       IntReq,
    input  logic       M_Eret,
    output logic       PC_En,
    output logic       FD_En,
    output logic       FD_Clr,
    output logic       DE_Clr,
    output logic       EM_Clr,
    output logic [1:0] PC_Sel,
    output logic       MD_Busy,
    output logic       Redir
);

    logic [0:0] state_q, state_d;
    logic [1:0] hold_q, hold_d;
    logic       stall_rs, stall_rt, stall_md, stall;
    logic       redir_take;
    logic       md_load;

    // Register-operand hazards against the E and M producers; $0 never stalls.
    always_comb begin
        stall_rs = (D_Rs != 5'd0) &&
                   (src_hazard(D_Rs, D_TuseRs, E_RegWrite, E_RegDst, E_Tnew) ||
                    src_hazard(D_Rs, D_TuseRs, M_RegWrite, M_RegDst, M_Tnew));
        stall_rt = (D_Rt != 5'd0) &&
                   (src_hazard(D_Rt, D_TuseRt, E_RegWrite, E_RegDst, E_Tnew) ||
                    src_hazard(D_Rt, D_TuseRt, M_RegWrite, M_RegDst, M_Tnew));
        stall_md = D_isMD && (MD_Busy || E_MDStart);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Requests are only honoured in RUN so one event produces one redirect.
    assign redir_take = (state_q == ST_RUN) && (IntReq || M_Eret);

    // An MDU start in a redirect cycle belongs to a flushed instruction.
    assign md_load = E_MDStart && !redir_take;

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_cnt (
        .clk_i    (Clk),
        .reset_i  (Reset),
        .load_i   (md_load),
        .is_div_i (E_MDIsDiv),
        .busy_o   (MD_Busy)
    );

    // Redirect FSM next state: RUN -> HOLD on a redirect, HOLD counts down back to RUN.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (state_q == ST_RUN) begin
            if (redir_take) begin
                state_d = ST_HOLD;
                hold_d  = 2'(REDIR_HOLD - 1);
            end
        end else begin
            if (hold_q == 2'd0) begin
                state_d = ST_RUN;
            end else begin
                hold_d = hold_q - 2'd1;
            end
        end
    end

    // FSM state registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_RUN;
            hold_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Pipeline register controls; reset forces free-running with no clears.
    always_comb begin
        PC_En  = 1'b1;
        FD_En  = 1'b1;
        FD_Clr = 1'b0;
        DE_Clr = 1'b0;
        EM_Clr = 1'b0;
        PC_Sel = PC_SEL_SEQ;
        if (!Reset) begin
            if (redir_take) begin
                PC_Sel = IntReq ? PC_SEL_EXC : PC_SEL_EPC;
                FD_Clr = 1'b1;
                DE_Clr = 1'b1;
                EM_Clr = 1'b1;
            end else if (stall) begin
                PC_En  = 1'b0;
                FD_En  = 1'b0;
                DE_Clr = 1'b1;
            end
        end
    end

    assign Redir = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TB_MULT_CYC   = 5;
    localparam int unsigned TB_DIV_CYC    = 10;
    localparam int unsigned TB_REDIR_HOLD = 1;

    // Output vector order: {PC_En, FD_En, FD_Clr, DE_Clr, EM_Clr, PC_Sel[1:0], MD_Busy, Redir}
    localparam logic [8:0] V_IDLE      = 9'b11000_00_0_0;
    localparam logic [8:0] V_STALL     = 9'b00010_00_0_0;
    localparam logic [8:0] V_EXC       = 9'b11111_01_0_0;
    localparam logic [8:0] V_EPC       = 9'b11111_10_0_0;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] D_Rs, D_Rt, E_RegDst, M_RegDst;
    logic [1:0] D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
    logic       D_isMD, E_RegWrite, M_RegWrite, E_MDStart, E_MDIsDiv, IntReq, M_Eret;
    logic       PC_En, FD_En, FD_Clr, DE_Clr, EM_Clr, MD_Busy, Redir;
    logic [1:0] PC_Sel;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(
        .MULT_CYC   (TB_MULT_CYC),
        .DIV_CYC    (TB_DIV_CYC),
        .REDIR_HOLD (TB_REDIR_HOLD)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .D_Rs       (D_Rs),
        .D_Rt       (D_Rt),
        .D_TuseRs   (D_TuseRs),
        .D_TuseRt   (D_TuseRt),
        .D_isMD     (D_isMD),
        .E_RegWrite (E_RegWrite),
        .E_RegDst   (E_RegDst),
        .E_Tnew     (E_Tnew),
        .M_RegWrite (M_RegWrite),
        .M_RegDst   (M_RegDst),
        .M_Tnew     (M_Tnew),
        .E_MDStart  (E_MDStart),
        .E_MDIsDiv  (E_MDIsDiv),
        .IntReq     (IntReq),
        .M_Eret     (M_Eret),
        .PC_En      (PC_En),
        .FD_En      (FD_En),
        .FD_Clr     (FD_Clr),
        .DE_Clr     (DE_Clr),
        .EM_Clr     (EM_Clr),
        .PC_Sel     (PC_Sel),
        .MD_Busy    (MD_Busy),
        .Redir      (Redir)
    );

    always #5 Clk = ~Clk;

    initial assert (TB_DIV_CYC <= 15);

    function automatic logic [8:0] outs();
        return {PC_En, FD_En, FD_Clr, DE_Clr, EM_Clr, PC_Sel, MD_Busy, Redir};
    endfunction

    task automatic clear_inputs();
        D_Rs = 5'd0; D_Rt = 5'd0; D_TuseRs = 2'd3; D_TuseRt = 2'd3; D_isMD = 1'b0;
        E_RegWrite = 1'b0; E_RegDst = 5'd0; E_Tnew = 2'd0;
        M_RegWrite = 1'b0; M_RegDst = 5'd0; M_Tnew = 2'd0;
        E_MDStart = 1'b0; E_MDIsDiv = 1'b0; IntReq = 1'b0; M_Eret = 1'b0;
    endtask

    task automatic advance();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1'b1;
        D_isMD = 1'b1; E_MDStart = 1'b1;  // would stall if not forced
        advance();
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL reset_forced got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
        Reset = 1'b0;
        clear_inputs();
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL reset_idle got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
    endtask

    task automatic test_data_hazard();
        // lw $1 in E, add reading $1 in D.
        clear_inputs();
        D_Rs = 5'd1; D_TuseRs = 2'd1; E_RegWrite = 1'b1; E_RegDst = 5'd1; E_Tnew = 2'd2;
        @(negedge Clk);
        total++;
        if (outs() !== V_STALL) begin
            $display("FAIL lw_use_stall got=%b want=%b", outs(), V_STALL); bad++;
        end
        advance();
        // lw now in M with Tnew=1: forwardable, no stall.
        E_RegWrite = 1'b0; M_RegWrite = 1'b1; M_RegDst = 5'd1; M_Tnew = 2'd1;
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL lw_use_resume got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
        // rt hazard against M.
        clear_inputs();
        D_Rt = 5'd5; D_TuseRt = 2'd0; M_RegWrite = 1'b1; M_RegDst = 5'd5; M_Tnew = 2'd1;
        @(negedge Clk);
        total++;
        if (outs() !== V_STALL) begin
            $display("FAIL rt_m_stall got=%b want=%b", outs(), V_STALL); bad++;
        end
        advance();
        // Operand not used (Tuse=3): no stall even with a matching producer.
        clear_inputs();
        D_Rs = 5'd7; D_TuseRs = 2'd3; E_RegWrite = 1'b1; E_RegDst = 5'd7; E_Tnew = 2'd2;
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL tuse_none got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        D_Rs = 5'd0; D_TuseRs = 2'd0; E_RegWrite = 1'b1; E_RegDst = 5'd0; E_Tnew = 2'd2;
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL zero_reg got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
        // Matching dst but producer does not write.
        clear_inputs();
        D_Rs = 5'd3; D_TuseRs = 2'd0; E_RegWrite = 1'b0; E_RegDst = 5'd3; E_Tnew = 2'd2;
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL no_write got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
    endtask

    task automatic test_md_div();
        clear_inputs();
        E_MDStart = 1'b1; E_MDIsDiv = 1'b1; D_isMD = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== V_STALL) begin
            $display("FAIL div_start_stall got=%b want=%b", outs(), V_STALL); bad++;
        end
        advance();
        E_MDStart = 1'b0; E_MDIsDiv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            total++;
            if (outs() !== (V_STALL | 9'b00000_00_1_0)) begin
                $display("FAIL div_busy_stall cyc=%0d got=%b want=%b", i, outs(),
                         V_STALL | 9'b00000_00_1_0);
                bad++;
            end
            advance();
        end
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL div_done got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
    endtask

    task automatic test_md_mult();
        clear_inputs();
        E_MDStart = 1'b1;  // mult, D not an MD instruction
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL mult_start got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
        E_MDStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            total++;
            if (outs() !== (V_IDLE | 9'b00000_00_1_0)) begin
                $display("FAIL mult_busy cyc=%0d got=%b want=%b", i, outs(),
                         V_IDLE | 9'b00000_00_1_0);
                bad++;
            end
            advance();
        end
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL mult_done got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
    endtask

    task automatic test_int_stall();
        clear_inputs();
        D_Rs = 5'd2; D_TuseRs = 2'd0; E_RegWrite = 1'b1; E_RegDst = 5'd2; E_Tnew = 2'd1;
        IntReq = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== V_EXC) begin
            $display("FAIL int_over_stall got=%b want=%b", outs(), V_EXC); bad++;
        end
        advance();
        // HOLD: second IntReq ignored, data stall still applies.
        @(negedge Clk);
        total++;
        if (outs() !== (V_STALL | 9'b00000_00_0_1)) begin
            $display("FAIL int_hold got=%b want=%b", outs(), V_STALL | 9'b00000_00_0_1); bad++;
        end
        advance();
        clear_inputs();
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL int_resume got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
        // ERET in RUN.
        M_Eret = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== V_EPC) begin
            $display("FAIL eret got=%b want=%b", outs(), V_EPC); bad++;
        end
        advance();
        M_Eret = 1'b0; IntReq = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== (V_IDLE | 9'b00000_00_0_1)) begin
            $display("FAIL eret_hold_ignore got=%b want=%b", outs(), V_IDLE | 9'b00000_00_0_1);
            bad++;
        end
        advance();
        // Back in RUN: IntReq wins over M_Eret.
        M_Eret = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== V_EXC) begin
            $display("FAIL int_prio got=%b want=%b", outs(), V_EXC); bad++;
        end
        advance();
        clear_inputs();
        advance();
    endtask

    task automatic test_int_mdstart();
        clear_inputs();
        IntReq = 1'b1; E_MDStart = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== V_EXC) begin
            $display("FAIL int_mdstart got=%b want=%b", outs(), V_EXC); bad++;
        end
        advance();
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            total++;
            if (MD_Busy !== 1'b0) begin
                $display("FAIL int_mdstart_busy cyc=%0d got=%b want=0", i, MD_Busy); bad++;
            end
            advance();
        end
    endtask

    task automatic test_redir_keeps_md();
        clear_inputs();
        E_MDStart = 1'b1;
        advance();
        E_MDStart = 1'b0; IntReq = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== (V_EXC | 9'b00000_00_1_0)) begin
            $display("FAIL redir_md_run got=%b want=%b", outs(), V_EXC | 9'b00000_00_1_0); bad++;
        end
        advance();
        IntReq = 1'b0;
        advance();
        advance();
        advance();
        // Counter: 5 at redirect, then 4,3,2,1 -> busy one more cycle.
        @(negedge Clk);
        total++;
        if (outs() !== (V_IDLE | 9'b00000_00_1_0)) begin
            $display("FAIL redir_md_last got=%b want=%b", outs(), V_IDLE | 9'b00000_00_1_0);
            bad++;
        end
        advance();
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL redir_md_done got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        E_MDStart = 1'b1; E_MDIsDiv = 1'b1;
        advance();                 // cnt 10
        clear_inputs();
        advance();                 // cnt 9
        advance();                 // cnt 8
        advance();                 // cnt 7
        IntReq = 1'b1;
        advance();                 // cnt 6, HOLD
        IntReq = 1'b0;
        Reset = 1'b1; D_isMD = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== (V_IDLE | 9'b00000_00_1_1)) begin
            $display("FAIL reset_mid_forced got=%b want=%b", outs(), V_IDLE | 9'b00000_00_1_1);
            bad++;
        end
        advance();
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if (outs() !== V_IDLE) begin
            $display("FAIL reset_mid_after got=%b want=%b", outs(), V_IDLE); bad++;
        end
        advance();
        clear_inputs();
    endtask

    initial begin
        Reset = 1'b1;
        clear_inputs();
        test_reset();
        test_data_hazard();
        test_zero_reg();
        test_md_div();
        test_md_mult();
        test_int_stall();
        test_int_mdstart();
        test_redir_keeps_md();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
